// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl: bridges the PicoSoC iomem master port to four decoded slaves.
// One transaction at a time: IDLE decodes addr[31:24], WAIT holds the slave
// request until it completes, and RESP pulses iomem_ready for one cycle.
// Unmapped addresses complete immediately with an error. Error status is
// sticky until err_clr.
// Optional build macro IOMEM_TIMEOUT_EN: adds a saturating 16-bit WAIT counter.
// When the counter reaches TIMEOUT_CYCLES, the access is aborted with error code 10.
module iomem_bus_ctrl #(
  parameter logic [7:0]  SLV0_BASE      = 8'h03,
  parameter logic [7:0]  SLV1_BASE      = 8'h05,
  parameter logic [7:0]  SLV2_BASE      = 8'h06,
  parameter logic [7:0]  SLV3_BASE      = 8'h07,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         iomem_valid,
  output logic         iomem_ready,
  input  logic [3:0]   iomem_wstrb,
  input  logic [31:0]  iomem_addr,
  input  logic [31:0]  iomem_wdata,
  output logic [31:0]  iomem_rdata,
  output logic [3:0]   s_valid,
  input  logic [3:0]   s_ready,
  input  logic [127:0] s_rdata,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  output logic [3:0]   s_wstrb,
  input  logic         err_clr,
  output logic         err_flag,
  output logic [1:0]   err_code,
  output logic [31:0]  err_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] BASES = {SLV3_BASE, SLV2_BASE, SLV1_BASE, SLV0_BASE};

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("iomem_bus_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state;
  logic [1:0]  sel;
  logic        hit;
  logic [1:0]  hit_idx;
  logic        accept;
  logic        ack;
  logic        tmo;
  logic        err_new;
  logic [1:0]  err_new_code;
  logic [31:0] err_new_addr;

  // Address decode: the lowest slave index wins when bases collide.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!hit && iomem_addr[31:24] == BASES[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign accept = (state == IDLE) && iomem_valid && !iomem_ready;
  // Only the selected slave's ready is looked at, and only while waiting.
  assign ack    = (state == WAIT) && s_ready[sel];

`ifdef IOMEM_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 16'd1;
  // A slave ready in the final cycle still wins over the abort.
  assign tmo     = (state == WAIT) && !s_ready[sel] && (cnt_inc >= TMO);

  // WAIT-cycle counter: cleared on accept, saturating while waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt_inc;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // New-error source: unmapped decode in IDLE, or timeout abort in WAIT.
  always_comb begin
    err_new      = 1'b0;
    err_new_code = '0;
    err_new_addr = '0;
    if (accept && !hit) begin
      err_new      = 1'b1;
      err_new_code = 2'b01;
      err_new_addr = iomem_addr;
    end else if (tmo) begin
      err_new      = 1'b1;
      err_new_code = 2'b10;
      err_new_addr = s_addr;
    end
  end

  // Transaction sequencer: request capture, slave handshake, and CPU response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      sel         <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      s_valid     <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_addr  <= iomem_addr;
            s_wdata <= iomem_wdata;
            s_wstrb <= iomem_wstrb;
            if (hit) begin
              s_valid <= 4'b0001 << hit_idx;
              sel     <= hit_idx;
              state   <= WAIT;
            end else begin
              iomem_rdata <= '0;
              iomem_ready <= 1'b1;
              state       <= RESP;
            end
          end
        end
        WAIT: begin
          if (ack) begin
            iomem_rdata <= s_rdata[{sel, 5'b0} +: 32];
            s_valid     <= '0;
            iomem_ready <= 1'b1;
            state       <= RESP;
          end else if (tmo) begin
            iomem_rdata <= '1;
            s_valid     <= '0;
            iomem_ready <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          iomem_ready <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          iomem_ready <= 1'b0;
          s_valid     <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Sticky error status: a new error overrides a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_flag <= 1'b0;
      err_code <= '0;
      err_addr <= '0;
    end else if (err_new) begin
      err_flag <= 1'b1;
      err_code <= err_new_code;
      err_addr <= err_new_addr;
    end else if (err_clr) begin
      err_flag <= 1'b0;
      err_code <= '0;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Self-checking bench for iomem_bus_ctrl.
// Expected behaviour comes from a transaction-level model: decode rule,
// completion cycle, read data, and sticky error state per access.
module tb_iomem_bus_ctrl;

  localparam int TMO = 8;
  localparam logic [7:0] BASE [4] = '{8'h03, 8'h05, 8'h06, 8'h07};

  logic         clk;
  logic         resetn;
  logic         iomem_valid;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb;
  logic [31:0]  iomem_addr;
  logic [31:0]  iomem_wdata;
  logic [31:0]  iomem_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         err_clr;
  logic         err_flag;
  logic [1:0]   err_code;
  logic [31:0]  err_addr;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the sticky error registers.
  logic        m_flag;
  logic [1:0]  m_code;
  logic [31:0] m_addr;

  iomem_bus_ctrl #(
    .SLV0_BASE      (8'h03),
    .SLV1_BASE      (8'h05),
    .SLV2_BASE      (8'h06),
    .SLV3_BASE      (8'h07),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .err_clr     (err_clr),
    .err_flag    (err_flag),
    .err_code    (err_code),
    .err_addr    (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a[31:24] == BASE[i]) return i;
    end
    return -1;
  endfunction

  // One CPU access. The slave acknowledges lat cycles after its request first appears.
  // Every cycle until completion is checked against the model.
  task automatic do_txn(input string name, input logic [31:0] addr,
                        input logic [3:0] wstrb, input logic [31:0] wdata,
                        input int lat, input logic [31:0] srd,
                        input bit clr, input bit noise);
    int          tgt;
    int          ack_c;
    int          rdy_c;
    bit          timed_out;
    logic [31:0] exp_rd;
    logic [3:0]  onehot;
    logic [3:0]  exp_sv;
    logic [3:0]  sr;
    tgt       = decode(addr);
    ack_c     = 1 + lat;
    timed_out = 1'b0;
    onehot    = '0;
`ifdef IOMEM_TIMEOUT_EN
    if (tgt >= 0 && ack_c > TMO) timed_out = 1'b1;
`endif
    if (tgt < 0) begin
      rdy_c  = 1;
      exp_rd = '0;
    end else if (timed_out) begin
      rdy_c  = TMO + 1;
      exp_rd = '1;
    end else begin
      rdy_c  = ack_c + 1;
      exp_rd = srd;
    end
    if (tgt >= 0) onehot = 4'b0001 << tgt;
    if (clr) begin
      m_flag = 1'b0; m_code = '0; m_addr = '0;
    end
    if (tgt < 0) begin
      m_flag = 1'b1; m_code = 2'b01; m_addr = addr;
    end else if (timed_out) begin
      m_flag = 1'b1; m_code = 2'b10; m_addr = addr;
    end

    @(negedge clk);
    n_cmp++;
    if ({iomem_ready, s_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL %s idle: got ready/s_valid %b expected 00000", name, {iomem_ready, s_valid});
    end
    s_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (tgt >= 0) s_rdata[32*tgt +: 32] = srd;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    err_clr     = clr;
    s_ready     = noise ? 4'($urandom) : 4'b0;
    if (tgt >= 0) s_ready[tgt] = 1'b0;

    for (int c = 1; c <= rdy_c; c++) begin
      @(negedge clk);
      err_clr = 1'b0;
      exp_sv  = (c < rdy_c) ? onehot : 4'b0;
      n_cmp++;
      if ({iomem_ready, s_valid} !== {(c == rdy_c), exp_sv}) begin
        n_err++;
        $display("FAIL %s cycle %0d: got ready/s_valid %b expected %b", name, c,
                 {iomem_ready, s_valid}, {(c == rdy_c), exp_sv});
      end
      sr = noise ? 4'($urandom) : 4'b0;
      if (tgt >= 0) sr[tgt] = (c == ack_c);
      s_ready = sr;
      if (c == rdy_c) begin
        iomem_valid = 1'b0;
        n_cmp++;
        if (iomem_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL %s rdata: got %h expected %h", name, iomem_rdata, exp_rd);
        end
        n_cmp++;
        if ({s_addr, s_wdata, s_wstrb} !== {addr, wdata, wstrb}) begin
          n_err++;
          $display("FAIL %s s_bus: got %h/%h/%h expected %h/%h/%h", name,
                   s_addr, s_wdata, s_wstrb, addr, wdata, wstrb);
        end
        n_cmp++;
        if ({err_flag, err_code, err_addr} !== {m_flag, m_code, m_addr}) begin
          n_err++;
          $display("FAIL %s err: got %b/%b/%h expected %b/%b/%h", name,
                   err_flag, err_code, err_addr, m_flag, m_code, m_addr);
        end
      end
    end
    s_ready = '0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({iomem_ready, iomem_rdata, s_valid, s_addr, s_wdata, s_wstrb,
         err_flag, err_code, err_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got ready=%b rdata=%h sv=%b saddr=%h swdata=%h swstrb=%h err=%b/%b/%h expected all zero",
               iomem_ready, iomem_rdata, s_valid, s_addr, s_wdata, s_wstrb, err_flag, err_code, err_addr);
    end
    resetn = 1'b1;
    m_flag = 1'b0; m_code = '0; m_addr = '0;
  endtask

  task automatic test_write_zero_wait;
    do_txn("write_zero_wait", 32'h0300_0000, 4'hF, 32'h0000_0001, 0, 32'h1234_5678, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait;
    do_txn("read_wait", 32'h0500_0010, 4'h0, 32'h0, 5, 32'hCAFE_F00D, 1'b0, 1'b1);
  endtask

  task automatic test_unmapped;
    do_txn("unmapped", 32'h0900_0004, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    do_txn("timeout", 32'h0600_0020, 4'h0, 32'h0, 40, 32'h5A5A_A5A5, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      s_ready = 4'b0100;
      @(negedge clk);
      n_cmp++;
      if ({iomem_ready, s_valid} !== 5'b0) begin
        n_err++;
        $display("FAIL late_ready cycle %0d: got ready/s_valid %b expected 00000", c, {iomem_ready, s_valid});
      end
    end
    s_ready = '0;
  endtask

  task automatic test_err_clr;
    do_txn("clr_with_err", 32'h0A00_1234, 4'h0, 32'h0, 0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_flag = 1'b0; m_code = '0; m_addr = '0;
    n_cmp++;
    if ({err_flag, err_code, err_addr} !== 35'b0) begin
      n_err++;
      $display("FAIL clr_alone: got %b/%b/%h expected 0/00/00000000", err_flag, err_code, err_addr);
    end
  endtask

  task automatic test_back_to_back;
    do_txn("b2b_0", 32'h0300_0100, 4'h3, $urandom, 0, $urandom, 1'b0, 1'b0);
    do_txn("b2b_1", 32'h0700_0200, 4'h0, $urandom, 0, $urandom, 1'b0, 1'b1);
    do_txn("b2b_2", 32'h0600_0300, 4'hC, $urandom, 0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0040;
    iomem_wstrb = 4'h0;
    iomem_wdata = 32'h0;
    s_ready     = '0;
    repeat (3) @(negedge clk);
    iomem_valid = 1'b0;
    n_cmp++;
    if (s_valid !== 4'b0100) begin
      n_err++;
      $display("FAIL abort_pre: got s_valid %b expected 0100", s_valid);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({iomem_ready, s_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_async: got ready/s_valid %b expected 00000", {iomem_ready, s_valid});
    end
    @(negedge clk);
    resetn = 1'b1;
    m_flag = 1'b0; m_code = '0; m_addr = '0;
    do_txn("after_abort", 32'h0300_0008, 4'h0, 32'h0, 1, 32'h0BAD_BEEF, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [7:0]  top;
    int          k;
    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 4);
      top = 8'($urandom);
      if (k < 4) top = BASE[k];
      a = {top, 24'($urandom)};
      do_txn("random", a, 4'($urandom), $urandom, $urandom_range(0, TMO + 2), $urandom,
             ($urandom_range(0, 4) == 0), 1'b1);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    iomem_wstrb = '0;
    s_ready     = '0;
    s_rdata     = '0;
    err_clr     = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_unmapped();
    test_timeout();
    test_err_clr();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
